// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    // Bytes per instruction; the sequential PC step.
    localparam int INSTR_BYTES = 4;

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - instruction fetch FSM between the PC register and instruction memory
//
// Purpose:
//   Fetches the instruction at current_address over a req/ack memory port,
//   holds it for decode behind a valid/ready handshake and computes the next
//   PC (PC+4, branch target, or hold). Bus errors, fetch timeouts and
//   misaligned branch targets raise a sticky fault that only reset clears.
//
// Build option:
//   FETCH_PERF_CNT_EN - adds perf_retired / perf_stall event counters.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   current_address     registered PC value
//   new_address         next PC, sampled by the PC register every edge
//   imem_req/imem_addr  fetch request and address
//   imem_ack/rdata/err  fetch completion, instruction word, bus error
//   instr/instr_valid   held instruction to decode
//   instr_ready         decode consumes instr
//   branch_taken/target redirect, qualified by instr_valid & instr_ready
//   fault/fault_addr    sticky fault flag and offending address
//   perf_retired        (option) retired instruction count
//   perf_stall          (option) S_REQ cycles without ack
module fetch_control
    import fetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] current_address,
    output logic [ADDR_W-1:0] new_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_e      state_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] fault_addr_q;
    logic [CNT_W-1:0]  tout_cnt_q;

    logic handshake;
    logic target_misaligned;
    logic retire;

    // A consumed instruction either retires (PC moves) or, for a misaligned
    // branch, turns into a fault with the PC held.
    assign handshake         = (state_q == S_VALID) && instr_ready;
    assign target_misaligned = (branch_target[1:0] & ALIGN_MASK) != 2'b00;
    assign retire            = handshake && !(branch_taken && target_misaligned);

    always_comb begin
        new_address = current_address;
        if (retire) begin
            if (branch_taken) begin
                new_address = branch_target;
            end else begin
                // Modulo 2^ADDR_W wrap is intended.
                new_address = current_address + ADDR_W'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            fault_addr_q <= '0;
            tout_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        tout_cnt_q <= '0;
                        if (imem_err) begin
                            fault_addr_q <= current_address;
                            state_q      <= S_FAULT;
                        end else begin
                            instr_q <= imem_rdata;
                            state_q <= S_VALID;
                        end
                    end else if (tout_cnt_q == TOUT_LAST) begin
                        // This is the TIMEOUT_CYCLES-th cycle without an ack.
                        tout_cnt_q   <= '0;
                        fault_addr_q <= current_address;
                        state_q      <= S_FAULT;
                    end else begin
                        tout_cnt_q <= tout_cnt_q + 1'b1;
                    end
                end
                S_VALID: begin
                    if (handshake) begin
                        if (branch_taken && target_misaligned) begin
                            fault_addr_q <= branch_target;
                            state_q      <= S_FAULT;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= S_FAULT;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset drops
    // imem_req immediately even in the middle of a request.
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = current_address;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_VALID);
    assign fault       = (state_q == S_FAULT);
    assign fault_addr  = fault_addr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_retired_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (retire) begin
                perf_retired_q <= perf_retired_q + 32'd1;
            end
            if ((state_q == S_REQ) && !imem_ack) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// tb/tb_fetch_control.sv - directed self-checking bench for fetch_control
module tb_fetch_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc = 32'h0;
    logic [31:0] new_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fault;
    logic [31:0] fault_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;
`endif

    logic        pc_force;
    logic [31:0] pc_force_val;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_control #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .current_address(pc),
        .new_address    (new_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .fault          (fault),
        .fault_addr     (fault_addr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_retired   (perf_retired),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // PC register fed by new_address, with a bench override for jumping to test addresses.
    always @(posedge clk) begin
        pc <= pc_force ? pc_force_val : new_address;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with the PC loaded, then release and step through S_IDLE into S_REQ.
    task automatic do_reset(input logic [31:0] start_pc);
        reset        = 1'b1;
        pc_force     = 1'b1;
        pc_force_val = start_pc;
        imem_ack     = 1'b0;
        imem_err     = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();
        reset    = 1'b0;
        pc_force = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        pc_force      = 1'b1;
        pc_force_val  = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        imem_err      = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        #12;

        // Reset state
        check_eq("rst_req",        32'(imem_req), 32'd0);
        check_eq("rst_valid",      32'(instr_valid), 32'd0);
        check_eq("rst_fault",      32'(fault), 32'd0);
        check_eq("rst_instr",      instr, 32'h0);
        check_eq("rst_fault_addr", fault_addr, 32'h0);
        check_eq("rst_new_addr",   new_address, 32'h0);

        // 1: basic fetch and sequential retire
        reset    = 1'b0;
        pc_force = 1'b0;
        #1;
        check_eq("idle_req", 32'(imem_req), 32'd0);
        tick();
        check_eq("t1_req",  32'(imem_req), 32'd1);
        check_eq("t1_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        #1;
        check_eq("t1_new_hold", new_address, 32'h0);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        #1;
        check_eq("t1_valid", 32'(instr_valid), 32'd1);
        check_eq("t1_instr", instr, 32'h0050_0093);
        check_eq("t1_new_noready", new_address, 32'h0);
        instr_ready = 1'b1;
        #1;
        check_eq("t1_new_pc4", new_address, 32'h4);
        tick();
        instr_ready = 1'b0;
        #1;
        check_eq("t1_req2",  32'(imem_req), 32'd1);
        check_eq("t1_addr2", imem_addr, 32'h4);

        // 3: ack delayed three cycles
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t3_req",  32'(imem_req), 32'd1);
            check_eq("t3_addr", imem_addr, 32'h4);
            check_eq("t3_new",  new_address, 32'h4);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0113;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;

        // 4: ready held low; branch pulses without ready are ignored
        branch_target = 32'h200;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 1) || (i == 3);
            #1;
            check_eq("t4_valid", 32'(instr_valid), 32'd1);
            check_eq("t4_instr", instr, 32'h00A0_0113);
            check_eq("t4_new",   new_address, 32'h4);
            tick();
        end
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        #1;
        check_eq("t4_new_pc8", new_address, 32'h8);
        tick();
        instr_ready = 1'b0;

        // 2: aligned branch from 0x40
        pc_force     = 1'b1;
        pc_force_val = 32'h40;
        tick();
        pc_force   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        #1;
        check_eq("t2_addr40", imem_addr, 32'h40);
        tick();
        imem_ack      = 1'b0;
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        check_eq("t2_new_tgt", new_address, 32'h100);
        tick();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        #1;
        check_eq("t2_req",  32'(imem_req), 32'd1);
        check_eq("t2_addr", imem_addr, 32'h100);

        // 6: PC+4 wraps to zero without a fault
        pc_force     = 1'b1;
        pc_force_val = 32'hFFFF_FFFC;
        imem_ack     = 1'b1;
        tick();
        pc_force = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        #1;
        check_eq("t6_valid", 32'(instr_valid), 32'd1);
        check_eq("t6_new_wrap", new_address, 32'h0);
        tick();
        instr_ready = 1'b0;
        #1;
        check_eq("t6_req",   32'(imem_req), 32'd1);
        check_eq("t6_addr",  imem_addr, 32'h0);
        check_eq("t6_fault", 32'(fault), 32'd0);

        // 5a: misaligned branch target
        imem_ack = 1'b1;
        tick();
        imem_ack      = 1'b0;
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        #1;
        check_eq("t5_new_hold", new_address, 32'h0);
        tick();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        #1;
        check_eq("t5_fault",      32'(fault), 32'd1);
        check_eq("t5_fault_addr", fault_addr, 32'h102);
        check_eq("t5_req",        32'(imem_req), 32'd0);
        check_eq("t5_valid",      32'(instr_valid), 32'd0);
        check_eq("t5_new",        new_address, 32'h0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        #1;
        check_eq("t5_sticky", 32'(fault), 32'd1);
        check_eq("t5_req2",   32'(imem_req), 32'd0);

        // Reset mid-request drops imem_req without waiting for a clock edge
        do_reset(32'h80);
        check_eq("rst_mid_pre", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_req", 32'(imem_req), 32'd0);

        // 5b: bus error at 0x80
        do_reset(32'h80);
        imem_ack = 1'b1;
        imem_err = 1'b1;
        tick();
        imem_ack = 1'b0;
        imem_err = 1'b0;
        #1;
        check_eq("t5b_fault",      32'(fault), 32'd1);
        check_eq("t5b_fault_addr", fault_addr, 32'h80);
        check_eq("t5b_req",        32'(imem_req), 32'd0);

        // 5c: timeout after four ackless S_REQ cycles
        do_reset(32'h300);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("t5c_req",      32'(imem_req), 32'd1);
            check_eq("t5c_no_fault", 32'(fault), 32'd0);
            tick();
        end
        #1;
        check_eq("t5c_fault",      32'(fault), 32'd1);
        check_eq("t5c_fault_addr", fault_addr, 32'h300);

`ifdef FETCH_PERF_CNT_EN
        // Perf counters: 3 retires and 2 stalls
        do_reset(32'h0);
        check_eq("perf_rst_ret", perf_retired, 32'd0);
        check_eq("perf_rst_stl", perf_stall, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick();
            end
            imem_ack = 1'b1;
            tick();
            imem_ack    = 1'b0;
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
        end
        #1;
        check_eq("perf_retired", perf_retired, 32'd3);
        check_eq("perf_stall",   perf_stall, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
